// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: decoder/regfile inputs and PC/status outputs.
// PC_SINGLE_STEP_EN adds the StepMode/StepReq controls.
interface pc_fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
);
    logic              Stall;
    logic [1:0]        PCSrc;
    logic [31:0]       Imm;
    logic [31:0]       RS1Data;
    logic [31:0]       IDataIn;
    logic [ADDR_W-1:0] IAddr;
    logic [31:0]       PC;
    logic [31:0]       PCPlus4;
    logic              InstValid;
    logic              Halted;
    logic              MisalignErr;
    logic [CNT_W-1:0]  InstCount;
`ifdef PC_SINGLE_STEP_EN
    logic              StepMode;
    logic              StepReq;
`endif

    modport master (
        output Stall, PCSrc, Imm, RS1Data, IDataIn,
`ifdef PC_SINGLE_STEP_EN
        output StepMode, StepReq,
`endif
        input  IAddr, PC, PCPlus4, InstValid, Halted,
        input  MisalignErr, InstCount
    );

    modport slave (
        input  Stall, PCSrc, Imm, RS1Data, IDataIn,
`ifdef PC_SINGLE_STEP_EN
        input  StepMode, StepReq,
`endif
        output IAddr, PC, PCPlus4, InstValid, Halted,
        output MisalignErr, InstCount
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC / fetch control: next-PC select, ECALL halt, misalign trap, retire count.
// Optional single-step gating when PC_SINGLE_STEP_EN is defined.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 8,
    parameter int          CNT_W    = 16
) (
    input logic               CLK,
    input logic               Reset,
    pc_fetch_unit_if.slave    bus
);
    typedef enum logic [1:0] {RUN, HALT, ERR} state_t;

    state_t             state_q;
    logic [31:0]        pc_q;
    logic [31:0]        pc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               valid_q;
    logic               halt_q;
    logic               err_q;
    logic               is_ecall;
    logic               misal;
    logic               adv;
    logic [31:0]        jalr_sum;

    assign jalr_sum = bus.RS1Data + bus.Imm;

    always_comb begin
        pc_d = pc_q + 32'd4;
        case (bus.PCSrc)
            2'b01, 2'b10: pc_d = pc_q + bus.Imm;
            2'b11:        pc_d = {jalr_sum[31:1], 1'b0};
            default:      pc_d = pc_q + 32'd4;
        endcase
    end

    assign is_ecall = (bus.IDataIn[6:0] == 7'b1110011)
                   && (bus.IDataIn[14:12] == 3'b000)
                   && (bus.IDataIn[31:20] == 12'h000);
    assign misal = (pc_d[1:0] != 2'b00);
    assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef PC_SINGLE_STEP_EN
    logic step_q;

    always_ff @(posedge CLK) begin
        if (!Reset) step_q <= 1'b0;
        else        step_q <= bus.StepReq;
    end

    // In step mode only a fresh StepReq rising edge lets the PC move.
    assign adv = !bus.Stall
              && (!bus.StepMode || (bus.StepReq && !step_q));
`else
    assign adv = !bus.Stall;
`endif

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (adv) begin
                        if (is_ecall) begin
                            state_q <= HALT;
                            cnt_q   <= cnt_d;
                            valid_q <= 1'b0;
                            halt_q  <= 1'b1;
                        end else if (misal) begin
                            state_q <= ERR;
                            valid_q <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            pc_q  <= pc_d;
                            cnt_q <= cnt_d;
                        end
                    end
                end
                HALT, ERR: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= ERR;
                    valid_q <= 1'b0;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.IAddr       = pc_q[ADDR_W-1:0];
    assign bus.PC          = pc_q;
    assign bus.PCPlus4     = pc_q + 32'd4;
    assign bus.InstValid   = valid_q;
    assign bus.Halted      = halt_q;
    assign bus.MisalignErr = err_q;
    assign bus.InstCount   = cnt_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed literal checks plus randomized run
// against an architectural model of PC, retire count and run/halt/error.
module tb_pc_fetch_unit;
    localparam int CW = 5;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pc_fetch_unit_if #(.ADDR_W(8), .CNT_W(CW)) bus ();

    pc_fetch_unit #(
        .RESET_PC(32'h0),
        .ADDR_W  (8),
        .CNT_W   (CW)
    ) dut (
        .CLK  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    // Architectural model: 0 = running, 1 = halted, 2 = error
    logic [31:0] m_pc;
    int          m_cnt;
    int          m_st;
    bit          m_ok = 1'b0;
    logic        m_sq;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, a, e, $time);
        end
    endtask

    always @(posedge clk) begin : model
        logic [31:0] tgt;
        logic [31:0] s;
        bit          go;
        bit          ec;
        if (!rst) begin
            m_pc  = 32'h0;
            m_cnt = 0;
            m_st  = 0;
            m_ok  = 1'b1;
        end else if (m_st == 0) begin
            go = !bus.Stall;
`ifdef PC_SINGLE_STEP_EN
            if (bus.StepMode) go = go && bus.StepReq && !m_sq;
`endif
            if (go) begin
                s = bus.RS1Data + bus.Imm;
                if (bus.PCSrc == 2'd0)      tgt = m_pc + 4;
                else if (bus.PCSrc == 2'd3) tgt = s - (s % 2);
                else                        tgt = m_pc + bus.Imm;
                ec = bus.IDataIn[6:0] == 7'h73
                  && bus.IDataIn[14:12] == 3'd0
                  && bus.IDataIn[31:20] == 12'd0;
                if (ec) begin
                    m_st  = 1;
                    m_cnt = (m_cnt < 2**CW - 1) ? m_cnt + 1 : m_cnt;
                end else if (tgt % 4 != 0) begin
                    m_st = 2;
                end else begin
                    m_pc  = tgt;
                    m_cnt = (m_cnt < 2**CW - 1) ? m_cnt + 1 : m_cnt;
                end
            end
        end
`ifdef PC_SINGLE_STEP_EN
        m_sq = rst ? bus.StepReq : 1'b0;
`endif
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("pc",    bus.PC, m_pc);
            chk("iaddr", {24'h0, bus.IAddr}, {24'h0, m_pc[7:0]});
            chk("pc4",   bus.PCPlus4, m_pc + 32'd4);
            chk("cnt",   32'(bus.InstCount), 32'(m_cnt));
            chk("valid", {31'h0, bus.InstValid}, {31'h0, m_st == 0});
            chk("halt",  {31'h0, bus.Halted}, {31'h0, m_st == 1});
            chk("err",   {31'h0, bus.MisalignErr}, {31'h0, m_st == 2});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst         = 1'b0;
        bus.Stall   = 1'b0;
        bus.PCSrc   = 2'd0;
        bus.Imm     = 32'h0;
        bus.RS1Data = 32'h0;
        bus.IDataIn = NOP;
`ifdef PC_SINGLE_STEP_EN
        bus.StepMode = 1'b0;
        bus.StepReq  = 1'b0;
`endif
        repeat (2) tick();
        rst = 1'b1;
        chk("rst_pc",    bus.PC, 32'h0);
        chk("rst_iaddr", {24'h0, bus.IAddr}, 32'h0);
        chk("rst_cnt",   32'(bus.InstCount), 32'h0);
        chk("rst_valid", {31'h0, bus.InstValid}, 32'h1);
        chk("rst_halt",  {31'h0, bus.Halted}, 32'h0);

        repeat (5) tick();
        chk("seq_pc",    bus.PC, 32'h14);
        chk("seq_iaddr", {24'h0, bus.IAddr}, 32'h14);
        chk("seq_cnt",   32'(bus.InstCount), 32'd5);
        bus.Stall = 1'b1;
        repeat (3) tick();
        chk("stall_pc",  bus.PC, 32'h14);
        chk("stall_cnt", 32'(bus.InstCount), 32'd5);
        bus.Stall = 1'b0;

        repeat (2) tick();
        chk("pre_br_pc", bus.PC, 32'h1C);
        bus.PCSrc = 2'd1;
        bus.Imm   = 32'hFFFF_FFFC;
        tick();
        chk("br_pc", bus.PC, 32'h18);
        bus.PCSrc = 2'd2;
        bus.Imm   = 32'h30;
        tick();
        chk("jal0_pc",  bus.PC, 32'h48);
        chk("jal_pc4",  bus.PCPlus4, 32'h4C);
        bus.Imm = 32'h8;
        tick();
        chk("jal_pc",  bus.PC, 32'h50);
        chk("jal_cnt", 32'(bus.InstCount), 32'd10);
        bus.PCSrc   = 2'd3;
        bus.RS1Data = 32'h49;
        bus.Imm     = 32'h3;
        tick();
        chk("jalr_pc", bus.PC, 32'h4C);
        bus.PCSrc = 2'd0;
        tick();
        chk("pre_ec_pc", bus.PC, 32'h50);
        bus.IDataIn = 32'h0000_0073;
        tick();
        chk("ec_halt", {31'h0, bus.Halted}, 32'h1);
        chk("ec_pc",   bus.PC, 32'h50);
        chk("ec_cnt",  32'(bus.InstCount), 32'd13);
        bus.IDataIn = NOP;
        bus.PCSrc   = 2'd1;
        repeat (2) tick();
        chk("halt_hold", bus.PC, 32'h50);
        do_reset();
        chk("rr_pc",   bus.PC, 32'h0);
        chk("rr_halt", {31'h0, bus.Halted}, 32'h0);

        bus.PCSrc   = 2'd3;
        bus.RS1Data = 32'h42;
        bus.Imm     = 32'h0;
        tick();
        chk("mis_err", {31'h0, bus.MisalignErr}, 32'h1);
        chk("mis_pc",  bus.PC, 32'h0);
        chk("mis_cnt", 32'(bus.InstCount), 32'h0);
        bus.PCSrc = 2'd0;
        repeat (2) tick();
        chk("err_hold", bus.PC, 32'h0);

        do_reset();
        bus.IDataIn = 32'h0007_8073;
        tick();
        chk("ecx_halt", {31'h0, bus.Halted}, 32'h1);
        chk("ecx_cnt",  32'(bus.InstCount), 32'd1);
        do_reset();
        bus.IDataIn = 32'b000000000000_xxxxx_000_xxxxx_1110011;
        tick();
        chk("ecz_halt", {31'h0, bus.Halted}, 32'h1);
        bus.IDataIn = NOP;

        do_reset();
        repeat (70) tick();
        chk("sat_cnt",   32'(bus.InstCount), 32'd31);
        chk("wrap_pc",   bus.PC, 32'h118);
        chk("wrap_addr", {24'h0, bus.IAddr}, 32'h18);

`ifdef PC_SINGLE_STEP_EN
        bus.StepReq = 1'b0;
        do_reset();
        bus.StepMode = 1'b1;
        bus.StepReq  = 1'b1;
        repeat (4) tick();
        chk("step_hold", bus.PC, 32'h4);
        repeat (3) begin
            bus.StepReq = 1'b0;
            tick();
            bus.StepReq = 1'b1;
            tick();
        end
        chk("step_tog", bus.PC, 32'h10);
        bus.StepMode = 1'b0;
        bus.StepReq  = 1'b0;
`endif

        for (int i = 0; i < 2000; i++) begin
            if (m_st != 0) rst = ($urandom_range(0, 7) != 0);
            else           rst = ($urandom_range(0, 199) != 0);
            bus.Stall = ($urandom_range(0, 4) == 0);
            bus.PCSrc = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) bus.Imm = $urandom;
            else bus.Imm = 32'($signed($urandom_range(0, 64)) - 32) <<< 2;
            bus.RS1Data = $urandom;
            if ($urandom_range(0, 9) != 0) bus.RS1Data[1:0] = 2'b00;
            if ($urandom_range(0, 49) == 0) begin
                bus.IDataIn = $urandom;
                bus.IDataIn[31:20] = 12'h000;
                bus.IDataIn[14:12] = 3'b000;
                bus.IDataIn[6:0]   = 7'h73;
            end else begin
                bus.IDataIn = $urandom;
            end
`ifdef PC_SINGLE_STEP_EN
            bus.StepMode = ($urandom_range(0, 2) == 0);
            bus.StepReq  = 1'($urandom_range(0, 1));
`endif
            tick();
        end

        rst = 1'b1;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and fetch-control stage that sits directly upstream of the instruction memory in the single-cycle RV32I core. It holds the architectural PC and drives the byte address of the instruction memory every cycle. It computes the next PC from the sequential, branch, JAL and JALR sources. It detects ECALL in the returned instruction word and halts there, traps misaligned control-flow targets, and counts retired instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 8, width of instruction-memory byte address output
CNT_W, 16, width of retired-instruction counter

Ports:
CLK  input  1  system clock, rising-edge active
Reset  input  1  synchronous, active-low reset
Stall  input  1  hold PC this cycle; no retire
PCSrc  input  2  next-PC select: 00 PC+4, 01 branch taken PC+Imm, 10 JAL PC+Imm, 11 JALR (RS1Data+Imm)&~1
Imm  input  32  sign-extended immediate from the decoder
RS1Data  input  32  rs1 register value, used by JALR
IDataIn  input  32  instruction word returned by instruction memory for the current PC
IAddr  output  ADDR_W  instruction-memory byte address, equal to PC[ADDR_W-1:0]
PC  output  32  current program counter
PCPlus4  output  32  PC+4, used for rd writeback of JAL/JALR
InstValid  output  1  1 while in RUN state
Halted  output  1  1 in HALT state
MisalignErr  output  1  1 in ERR state
InstCount  output  CNT_W  retired-instruction count

Behaviour:
- Reset is sampled on the rising CLK edge when Reset==0. It sets PC=RESET_PC, state=RUN, InstCount=0, Halted=0, MisalignErr=0 and InstValid=1. Reset overrides every other input, including in HALT and ERR.
- Combinational outputs:
  - IAddr=PC[ADDR_W-1:0] with no latency; PCs beyond 2^ADDR_W wrap modulo 2^ADDR_W on IAddr only.
  - PCPlus4=PC+4, 32-bit wrap.
- NextPC arithmetic: all 32-bit two's-complement with wrap. For JALR, bit 0 of the sum is cleared before the alignment check.
- ECALL decode: IDataIn[6:0]==7'b1110011 && IDataIn[14:12]==3'b000 && IDataIn[31:20]==12'h000. rs1 and rd fields are ignored and may be X.
- Misalign: NextPC[1:0]!=2'b00.
- States:
  - RUN, the reset state.
  - HALT, terminal until reset.
  - ERR, terminal until reset.
- Per-edge priority in RUN, with Reset deasserted:
  1. Stall==1: PC and InstCount hold; state stays RUN.
  2. ECALL decoded: PC holds at the ECALL address; InstCount+1; state goes to HALT.
  3. Misaligned NextPC: PC holds at the offending instruction; InstCount unchanged; state goes to ERR.
  4. Otherwise: PC=NextPC; InstCount+1.
- In HALT and ERR, PC, InstCount and state hold regardless of Stall, PCSrc or IDataIn. InstValid=0.
- InstCount saturates at all-ones and does not wrap.
- Stall asserted together with an ECALL word means the ECALL does not retire that cycle.
- Registered outputs update on the same edge as the state change, with one-cycle visibility. After the ECALL edge, Halted=1 and PC still equals the ECALL address.

Optional Feature:
Macro: PC_SINGLE_STEP_EN.
- Defined:
  - Adds input StepMode (1 bit) and input StepReq (1 bit).
  - A registered copy of StepReq gives rising-edge detection.
  - With StepMode==1, a RUN-state advance (rule 2, 3 or 4) happens only on a cycle where a StepReq rising edge was detected. Any other cycle behaves like Stall.
  - A held-high StepReq yields exactly one advance.
  - With StepMode==0, behaviour is identical to the undefined build.
  - The StepReq history register resets to 0.
- Undefined: the ports are absent and the block advances every non-stalled RUN cycle.

Test Plan:
- Reset: Reset=0 for 2 cycles, then Reset=1 -> PC=0, IAddr=0, InstCount=0, InstValid=1, Halted=0.
- Sequential run: PCSrc=00, non-ECALL IDataIn, 5 edges -> PC=0x14, IAddr=0x14, InstCount=5. Then Stall=1 for 3 edges -> PC and count unchanged.
- Branches:
  - PC=0x1C, PCSrc=01, Imm=0xFFFFFFFC -> PC=0x18.
  - PC=0x48, PCSrc=10, Imm=0x8 -> PC=0x50, PCPlus4 before the edge is 0x4C.
- JALR: RS1Data=0x49, Imm=0x3 -> PC=0x4C. RS1Data=0x42, Imm=0 -> MisalignErr=1, PC holds, InstCount unchanged, later edges have no effect.
- ECALL: at PC=0x50, IDataIn=0x00000073 (also 0x0007_8073-style with rs1/rd bits set) -> Halted=1, PC=0x50, InstCount+1. Then Reset=0 for one edge -> PC=0, Halted=0.
- Step (PC_SINGLE_STEP_EN): StepMode=1, StepReq held high for 4 cycles -> exactly one advance (PC 0x0->0x4). Toggling StepReq 3 times -> PC=0x10.
